// File: rtl/washer_plant_emulator_pkg.sv
// Shared washer plant constants, state encodings and the drum ramp step function.
package washer_plant_emulator_pkg;

  localparam int unsigned TICK_DIV_DEF       = 4;
  localparam int unsigned FILL_RATE_DEF      = 8;
  localparam int unsigned DRAIN_RATE_DEF     = 16;
  localparam int unsigned AMBIENT_TEMP_DEF   = 20;
  localparam int unsigned MAX_TEMP_DEF       = 95;
  localparam int unsigned HEAT_TICKS_DEF     = 2;
  localparam int unsigned COOL_TICKS_DEF     = 8;
  localparam int unsigned HEAT_MIN_LEVEL_DEF = 100;
  localparam int unsigned ACCEL_DEF          = 50;
  localparam int unsigned VIB_THRESH_DEF     = 800;
  localparam int unsigned VIB_HOLD_DEF       = 4;

  localparam int unsigned LEVEL_W   = 10;
  localparam int unsigned TEMP_W    = 7;
  localparam int unsigned SPEED_W   = 11;
  localparam int unsigned LVL_SUM_W = 12;
  localparam int unsigned DIV_W     = 8;
  localparam int unsigned VCNT_W    = 8;
  localparam int unsigned LEVEL_MAX = 1023;

  typedef enum logic [1:0] {
    V_IDLE = 2'd0,
    V_ARM  = 2'd1,
    V_VIB  = 2'd2
  } vib_state_e;

  typedef enum logic {
    T_COOL = 1'b0,
    T_HEAT = 1'b1
  } temp_mode_e;

  // One ramp step: snap to target when within accel, else move accel toward it.
  function automatic logic [SPEED_W-1:0] ramp_step(input logic [SPEED_W-1:0] actual,
                                                   input logic [SPEED_W-1:0] target,
                                                   input int unsigned        accel);
    logic signed [SPEED_W:0] diff;
    logic signed [SPEED_W:0] acc_s;
    diff  = $signed({1'b0, target}) - $signed({1'b0, actual});
    acc_s = $signed((SPEED_W+1)'(accel));
    if ((diff <= acc_s) && (diff >= -acc_s)) begin
      return target;
    end else if (diff > 0) begin
      return actual + SPEED_W'(accel);
    end else begin
      return actual - SPEED_W'(accel);
    end
  endfunction

endpackage

// File: rtl/washer_plant_emulator_if.sv
// Controller <-> plant signal bundle; master drives commands, slave returns sensors.
interface washer_plant_emulator_if;
  import washer_plant_emulator_pkg::*;

  logic               water_valve;
  logic               drain_pump;
  logic               heater;
  logic [SPEED_W-1:0] drum_motor;
  logic               inject_no_flow;
  logic               inject_blocked_drain;
  logic               inject_imbalance;
  logic [LEVEL_W-1:0] water_level_sensor;
  logic [TEMP_W-1:0]  temperature_adc_sensor;
  logic               vibration_sensor;
  logic [SPEED_W-1:0] drum_speed_actual;
  logic               tick;

  modport master (
    output water_valve, drain_pump, heater, drum_motor,
           inject_no_flow, inject_blocked_drain, inject_imbalance,
    input  water_level_sensor, temperature_adc_sensor, vibration_sensor,
           drum_speed_actual, tick
  );

  modport slave (
    input  water_valve, drain_pump, heater, drum_motor,
           inject_no_flow, inject_blocked_drain, inject_imbalance,
    output water_level_sensor, temperature_adc_sensor, vibration_sensor,
           drum_speed_actual, tick
  );

endinterface

// File: rtl/washer_plant_emulator_drum_speed_ramp.sv
// Drum speed slew limiter: moves actual toward target by ACCEL on each plant tick.
module drum_speed_ramp
  import washer_plant_emulator_pkg::*;
#(
  parameter int unsigned ACCEL = ACCEL_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [SPEED_W-1:0] target,
  output logic [SPEED_W-1:0] actual
);

  logic [SPEED_W-1:0] actual_q, actual_d;

  always_comb begin
    actual_d = actual_q;
    if (tick) begin
      actual_d = ramp_step(actual_q, target, ACCEL);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      actual_q <= '0;
    end else begin
      actual_q <= actual_d;
    end
  end

  assign actual = actual_q;

endmodule

// File: rtl/washer_plant_emulator.sv
// Washing machine plant emulator: water level, temperature, drum speed and
// vibration models, all advanced on a divided plant tick.
module washer_plant_emulator
  import washer_plant_emulator_pkg::*;
#(
  parameter int unsigned TICK_DIV       = TICK_DIV_DEF,
  parameter int unsigned FILL_RATE      = FILL_RATE_DEF,
  parameter int unsigned DRAIN_RATE     = DRAIN_RATE_DEF,
  parameter int unsigned AMBIENT_TEMP   = AMBIENT_TEMP_DEF,
  parameter int unsigned MAX_TEMP       = MAX_TEMP_DEF,
  parameter int unsigned HEAT_TICKS     = HEAT_TICKS_DEF,
  parameter int unsigned COOL_TICKS     = COOL_TICKS_DEF,
  parameter int unsigned HEAT_MIN_LEVEL = HEAT_MIN_LEVEL_DEF,
  parameter int unsigned ACCEL          = ACCEL_DEF,
  parameter int unsigned VIB_THRESH     = VIB_THRESH_DEF,
  parameter int unsigned VIB_HOLD       = VIB_HOLD_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               water_valve,
  input  logic               drain_pump,
  input  logic               heater,
  input  logic [SPEED_W-1:0] drum_motor,
  input  logic               inject_no_flow,
  input  logic               inject_blocked_drain,
  input  logic               inject_imbalance,
  output logic [LEVEL_W-1:0] water_level_sensor,
  output logic [TEMP_W-1:0]  temperature_adc_sensor,
  output logic               vibration_sensor,
  output logic [SPEED_W-1:0] drum_speed_actual,
  output logic               tick
);

  localparam int unsigned     PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               tick_q, tick_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [TEMP_W-1:0]  temp_q, temp_d;
  temp_mode_e         mode_q, mode_d;
  logic [DIV_W-1:0]   div_q, div_d;
  vib_state_e         vib_state_q, vib_state_d;
  logic [VCNT_W-1:0]  vib_cnt_q, vib_cnt_d;
  logic               vib_q, vib_d;

  logic                        fill_c, drain_c, hot_c;
  logic signed [LVL_SUM_W-1:0] level_sum_c;
  temp_mode_e                  mode_c;
  logic [DIV_W-1:0]            period_c, div_inc_c;
  logic [VCNT_W-1:0]           vib_cnt_inc_c;
  logic [SPEED_W-1:0]          speed_actual;

  // Tick is high while the prescaler sits on its last count.
  always_comb begin
    pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
    tick_d = (pre_d == PRE_LAST);
  end

  // Water level with saturation at both ends.
  always_comb begin
    fill_c      = water_valve && !inject_no_flow;
    drain_c     = drain_pump && !inject_blocked_drain;
    level_sum_c = LVL_SUM_W'(level_q);
    if (fill_c) begin
      level_sum_c = level_sum_c + LVL_SUM_W'(FILL_RATE);
    end
    if (drain_c) begin
      level_sum_c = level_sum_c - LVL_SUM_W'(DRAIN_RATE);
    end
    level_d = level_q;
    if (tick_q) begin
      if (level_sum_c < 0) begin
        level_d = '0;
      end else if (level_sum_c > $signed(LVL_SUM_W'(LEVEL_MAX))) begin
        level_d = LEVEL_W'(LEVEL_MAX);
      end else begin
        level_d = level_sum_c[LEVEL_W-1:0];
      end
    end
  end

  // Heating needs enough water; anything else (including dry heat) drifts to ambient.
  always_comb begin
    mode_c    = (heater && (level_q >= LEVEL_W'(HEAT_MIN_LEVEL))) ? T_HEAT : T_COOL;
    period_c  = (mode_c == T_HEAT) ? DIV_W'(HEAT_TICKS) : DIV_W'(COOL_TICKS);
    div_inc_c = ((mode_c != mode_q) ? '0 : div_q) + DIV_W'(1);
    mode_d    = mode_q;
    div_d     = div_q;
    temp_d    = temp_q;
    if (tick_q) begin
      mode_d = mode_c;
      div_d  = div_inc_c;
      if (div_inc_c >= period_c) begin
        div_d = '0;
        if (mode_c == T_HEAT) begin
          if (temp_q < TEMP_W'(MAX_TEMP)) temp_d = temp_q + TEMP_W'(1);
        end else if (temp_q > TEMP_W'(AMBIENT_TEMP)) begin
          temp_d = temp_q - TEMP_W'(1);
        end else if (temp_q < TEMP_W'(AMBIENT_TEMP)) begin
          temp_d = temp_q + TEMP_W'(1);
        end
      end
    end
  end

  drum_speed_ramp #(
    .ACCEL (ACCEL)
  ) u_ramp (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick_q),
    .target (drum_motor),
    .actual (speed_actual)
  );

  // Hot judges the speed the drum reaches on this tick.
  assign hot_c = inject_imbalance &&
                 (ramp_step(speed_actual, drum_motor, ACCEL) >= SPEED_W'(VIB_THRESH));

  always_comb begin
    vib_state_d   = vib_state_q;
    vib_cnt_d     = vib_cnt_q;
    vib_cnt_inc_c = vib_cnt_q + VCNT_W'(1);
    if (tick_q) begin
      unique case (vib_state_q)
        V_IDLE: begin
          if (hot_c) begin
            vib_state_d = V_ARM;
            vib_cnt_d   = VCNT_W'(1);
          end
        end
        V_ARM: begin
          if (!hot_c) begin
            vib_state_d = V_IDLE;
            vib_cnt_d   = '0;
          end else begin
            vib_cnt_d = vib_cnt_inc_c;
            if (vib_cnt_inc_c >= VCNT_W'(VIB_HOLD)) vib_state_d = V_VIB;
          end
        end
        V_VIB: begin
          if (!hot_c) begin
            vib_state_d = V_IDLE;
            vib_cnt_d   = '0;
          end
        end
        default: begin
          vib_state_d = V_IDLE;
          vib_cnt_d   = '0;
        end
      endcase
    end
    vib_d = (vib_state_d == V_VIB);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q       <= '0;
      tick_q      <= 1'b0;
      level_q     <= '0;
      temp_q      <= TEMP_W'(AMBIENT_TEMP);
      mode_q      <= T_COOL;
      div_q       <= '0;
      vib_state_q <= V_IDLE;
      vib_cnt_q   <= '0;
      vib_q       <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      tick_q      <= tick_d;
      level_q     <= level_d;
      temp_q      <= temp_d;
      mode_q      <= mode_d;
      div_q       <= div_d;
      vib_state_q <= vib_state_d;
      vib_cnt_q   <= vib_cnt_d;
      vib_q       <= vib_d;
    end
  end

  assign water_level_sensor     = level_q;
  assign temperature_adc_sensor = temp_q;
  assign vibration_sensor       = vib_q;
  assign drum_speed_actual      = speed_actual;
  assign tick                   = tick_q;

endmodule

// File: tb/tb_washer_plant_emulator.sv
// Bench for washer_plant_emulator: directed scenarios plus randomized run against a tick-level plant model.
module tb_washer_plant_emulator;
  import washer_plant_emulator_pkg::*;

  localparam int TDIV  = int'(TICK_DIV_DEF);
  localparam int FILL  = int'(FILL_RATE_DEF);
  localparam int DRAIN = int'(DRAIN_RATE_DEF);
  localparam int AMB   = int'(AMBIENT_TEMP_DEF);
  localparam int TMAX  = int'(MAX_TEMP_DEF);
  localparam int HTK   = int'(HEAT_TICKS_DEF);
  localparam int CTK   = int'(COOL_TICKS_DEF);
  localparam int HMIN  = int'(HEAT_MIN_LEVEL_DEF);
  localparam int ACC   = int'(ACCEL_DEF);
  localparam int VTH   = int'(VIB_THRESH_DEF);
  localparam int VHOLD = int'(VIB_HOLD_DEF);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  washer_plant_emulator_if wif();

  int n_checks = 0;
  int n_fail   = 0;

  int m_cycles, m_level, m_temp, m_speed, m_run, m_hot_run;
  bit m_heat, m_vib;

  always #5 clk = ~clk;

  washer_plant_emulator dut (
    .clk                    (clk),
    .reset                  (reset),
    .water_valve            (wif.water_valve),
    .drain_pump             (wif.drain_pump),
    .heater                 (wif.heater),
    .drum_motor             (wif.drum_motor),
    .inject_no_flow         (wif.inject_no_flow),
    .inject_blocked_drain   (wif.inject_blocked_drain),
    .inject_imbalance       (wif.inject_imbalance),
    .water_level_sensor     (wif.water_level_sensor),
    .temperature_adc_sensor (wif.temperature_adc_sensor),
    .vibration_sensor       (wif.vibration_sensor),
    .drum_speed_actual      (wif.drum_speed_actual),
    .tick                   (wif.tick)
  );

  task automatic drive_idle();
    wif.water_valve = 1'b0;  wif.drain_pump = 1'b0;  wif.heater = 1'b0;
    wif.drum_motor = '0;     wif.inject_no_flow = 1'b0;
    wif.inject_blocked_drain = 1'b0;  wif.inject_imbalance = 1'b0;
  endtask

  task automatic model_reset();
    m_cycles = 0; m_level = 0; m_temp = AMB; m_speed = 0;
    m_run = 0; m_hot_run = 0; m_heat = 1'b0; m_vib = 1'b0;
  endtask

  // Plant behaviour for one tick, from the inputs applied at that edge.
  task automatic model_tick();
    int lvl, diff, nxt;
    bit fill, drain, heat, hot;
    fill  = wif.water_valve && !wif.inject_no_flow;
    drain = wif.drain_pump && !wif.inject_blocked_drain;
    lvl = m_level + (fill ? FILL : 0) - (drain ? DRAIN : 0);
    if (lvl < 0) lvl = 0;
    if (lvl > 1023) lvl = 1023;
    heat = wif.heater && (m_level >= HMIN);
    if (heat != m_heat) m_run = 0;
    m_heat = heat;
    m_run++;
    if (heat) begin
      if ((m_run % HTK) == 0 && m_temp < TMAX) m_temp++;
    end else if ((m_run % CTK) == 0) begin
      if (m_temp > AMB) m_temp--;
      else if (m_temp < AMB) m_temp++;
    end
    diff = int'(wif.drum_motor) - m_speed;
    if (diff > ACC) nxt = m_speed + ACC;
    else if (diff < -ACC) nxt = m_speed - ACC;
    else nxt = int'(wif.drum_motor);
    hot = wif.inject_imbalance && (nxt >= VTH);
    m_hot_run = hot ? m_hot_run + 1 : 0;
    m_vib = (m_hot_run >= VHOLD);
    m_level = lvl;
    m_speed = nxt;
  endtask

  // Advance one clock, keep the model in step, land 1 time unit after the edge.
  task automatic step();
    bit was_tick;
    was_tick = (m_cycles % TDIV) == (TDIV - 1);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (was_tick) model_tick();
      m_cycles++;
    end
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic apply_reset();
    drive_idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (wif.water_level_sensor !== 10'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", wif.water_level_sensor); end
    n_checks++; if (wif.temperature_adc_sensor !== 7'd20) begin n_fail++; $display("FAIL reset_temp got=%0d exp=20", wif.temperature_adc_sensor); end
    n_checks++; if (wif.drum_speed_actual !== 11'd0) begin n_fail++; $display("FAIL reset_speed got=%0d exp=0", wif.drum_speed_actual); end
    n_checks++; if (wif.vibration_sensor !== 1'b0) begin n_fail++; $display("FAIL reset_vib got=%b exp=0", wif.vibration_sensor); end
    n_checks++; if (wif.tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%b exp=0", wif.tick); end
  endtask

  task automatic test_tick();
    logic exp_t;
    apply_reset();
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_t = ((k % TDIV) == (TDIV - 1));
      n_checks++; if (wif.tick !== exp_t) begin n_fail++; $display("FAIL tick_clk%0d got=%b exp=%b", k, wif.tick, exp_t); end
    end
  endtask

  task automatic test_fill();
    apply_reset();
    wif.water_valve = 1'b1;
    run(200);
    n_checks++; if (wif.water_level_sensor !== 10'd400) begin n_fail++; $display("FAIL fill_50ticks got=%0d exp=400", wif.water_level_sensor); end
    run(480);
    n_checks++; if (wif.water_level_sensor !== 10'd1023) begin n_fail++; $display("FAIL fill_saturate got=%0d exp=1023", wif.water_level_sensor); end
    run(40);
    n_checks++; if (wif.water_level_sensor !== 10'd1023) begin n_fail++; $display("FAIL fill_nowrap got=%0d exp=1023", wif.water_level_sensor); end
  endtask

  task automatic test_drain();
    apply_reset();
    wif.water_valve = 1'b1; run(200);
    wif.water_valve = 1'b0; wif.drain_pump = 1'b1;
    run(96);
    n_checks++; if (wif.water_level_sensor !== 10'd16) begin n_fail++; $display("FAIL drain_24ticks got=%0d exp=16", wif.water_level_sensor); end
    run(4);
    n_checks++; if (wif.water_level_sensor !== 10'd0) begin n_fail++; $display("FAIL drain_empty got=%0d exp=0", wif.water_level_sensor); end
    run(40);
    n_checks++; if (wif.water_level_sensor !== 10'd0) begin n_fail++; $display("FAIL drain_floor got=%0d exp=0", wif.water_level_sensor); end
    apply_reset();
    wif.water_valve = 1'b1; run(200);
    wif.water_valve = 1'b0; wif.drain_pump = 1'b1; wif.inject_blocked_drain = 1'b1;
    run(100);
    n_checks++; if (wif.water_level_sensor !== 10'd400) begin n_fail++; $display("FAIL drain_blocked got=%0d exp=400", wif.water_level_sensor); end
    apply_reset();
    wif.water_valve = 1'b1; wif.drain_pump = 1'b1;
    run(100);
    n_checks++; if (wif.water_level_sensor !== 10'd0) begin n_fail++; $display("FAIL drain_both_net got=%0d exp=0", wif.water_level_sensor); end
    apply_reset();
    wif.water_valve = 1'b1; wif.inject_no_flow = 1'b1;
    run(100);
    n_checks++; if (wif.water_level_sensor !== 10'd0) begin n_fail++; $display("FAIL fill_no_flow got=%0d exp=0", wif.water_level_sensor); end
  endtask

  task automatic test_heat();
    apply_reset();
    wif.water_valve = 1'b1; run(200);
    wif.water_valve = 1'b0; wif.heater = 1'b1;
    run(8);
    n_checks++; if (wif.temperature_adc_sensor !== 7'd21) begin n_fail++; $display("FAIL heat_2ticks got=%0d exp=21", wif.temperature_adc_sensor); end
    run(588);
    n_checks++; if (wif.temperature_adc_sensor !== 7'd94) begin n_fail++; $display("FAIL heat_149ticks got=%0d exp=94", wif.temperature_adc_sensor); end
    run(4);
    n_checks++; if (wif.temperature_adc_sensor !== 7'd95) begin n_fail++; $display("FAIL heat_150ticks got=%0d exp=95", wif.temperature_adc_sensor); end
    run(40);
    n_checks++; if (wif.temperature_adc_sensor !== 7'd95) begin n_fail++; $display("FAIL heat_max_hold got=%0d exp=95", wif.temperature_adc_sensor); end
    wif.heater = 1'b0;
    run(28);
    n_checks++; if (wif.temperature_adc_sensor !== 7'd95) begin n_fail++; $display("FAIL cool_7ticks got=%0d exp=95", wif.temperature_adc_sensor); end
    run(4);
    n_checks++; if (wif.temperature_adc_sensor !== 7'd94) begin n_fail++; $display("FAIL cool_8ticks got=%0d exp=94", wif.temperature_adc_sensor); end
  endtask

  task automatic test_dry_heat();
    apply_reset();
    wif.water_valve = 1'b1; run(24);
    wif.water_valve = 1'b0; wif.heater = 1'b1;
    run(200);
    n_checks++; if (wif.water_level_sensor !== 10'd48) begin n_fail++; $display("FAIL dry_level got=%0d exp=48", wif.water_level_sensor); end
    n_checks++; if (wif.temperature_adc_sensor !== 7'd20) begin n_fail++; $display("FAIL dry_heat_temp got=%0d exp=20", wif.temperature_adc_sensor); end
  endtask

  task automatic test_ramp();
    apply_reset();
    wif.drum_motor = 11'd1210;
    run(96);
    n_checks++; if (wif.drum_speed_actual !== 11'd1200) begin n_fail++; $display("FAIL ramp_up24 got=%0d exp=1200", wif.drum_speed_actual); end
    run(4);
    n_checks++; if (wif.drum_speed_actual !== 11'd1210) begin n_fail++; $display("FAIL ramp_snap got=%0d exp=1210", wif.drum_speed_actual); end
    wif.drum_motor = 11'd0;
    run(4);
    n_checks++; if (wif.drum_speed_actual !== 11'd1160) begin n_fail++; $display("FAIL ramp_down1 got=%0d exp=1160", wif.drum_speed_actual); end
    run(92);
    n_checks++; if (wif.drum_speed_actual !== 11'd10) begin n_fail++; $display("FAIL ramp_down24 got=%0d exp=10", wif.drum_speed_actual); end
    run(4);
    n_checks++; if (wif.drum_speed_actual !== 11'd0) begin n_fail++; $display("FAIL ramp_zero got=%0d exp=0", wif.drum_speed_actual); end
  endtask

  task automatic test_vibration();
    apply_reset();
    wif.inject_imbalance = 1'b1; wif.drum_motor = 11'd1400;
    run(64);
    n_checks++; if (wif.drum_speed_actual !== 11'd800) begin n_fail++; $display("FAIL vib_speed16 got=%0d exp=800", wif.drum_speed_actual); end
    n_checks++; if (wif.vibration_sensor !== 1'b0) begin n_fail++; $display("FAIL vib_tick16 got=%b exp=0", wif.vibration_sensor); end
    run(8);
    n_checks++; if (wif.vibration_sensor !== 1'b0) begin n_fail++; $display("FAIL vib_tick18 got=%b exp=0", wif.vibration_sensor); end
    run(4);
    n_checks++; if (wif.vibration_sensor !== 1'b1) begin n_fail++; $display("FAIL vib_tick19 got=%b exp=1", wif.vibration_sensor); end
    wif.inject_imbalance = 1'b0;
    run(4);
    n_checks++; if (wif.vibration_sensor !== 1'b0) begin n_fail++; $display("FAIL vib_clear got=%b exp=0", wif.vibration_sensor); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    wif.water_valve = 1'b1; wif.heater = 1'b1;
    wif.drum_motor = 11'd600; wif.inject_imbalance = 1'b1;
    run(51);
    n_checks++; if (wif.tick !== 1'b1) begin n_fail++; $display("FAIL mid_pre_tick got=%b exp=1", wif.tick); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (wif.water_level_sensor !== 10'd0) begin n_fail++; $display("FAIL mid_level got=%0d exp=0", wif.water_level_sensor); end
    n_checks++; if (wif.temperature_adc_sensor !== 7'd20) begin n_fail++; $display("FAIL mid_temp got=%0d exp=20", wif.temperature_adc_sensor); end
    n_checks++; if (wif.drum_speed_actual !== 11'd0) begin n_fail++; $display("FAIL mid_speed got=%0d exp=0", wif.drum_speed_actual); end
    n_checks++; if (wif.vibration_sensor !== 1'b0) begin n_fail++; $display("FAIL mid_vib got=%b exp=0", wif.vibration_sensor); end
    n_checks++; if (wif.tick !== 1'b0) begin n_fail++; $display("FAIL mid_tick got=%b exp=0", wif.tick); end
  endtask

  task automatic test_random();
    logic exp_t;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if ((i % 8) == 0) begin
        wif.water_valve          = 1'($urandom_range(0, 3) != 0);
        wif.drain_pump           = 1'($urandom_range(0, 3) == 0);
        wif.heater               = 1'($urandom_range(0, 1));
        wif.inject_no_flow       = 1'($urandom_range(0, 7) == 0);
        wif.inject_blocked_drain = 1'($urandom_range(0, 7) == 0);
      end
      if ((i % 64) == 0) begin
        wif.drum_motor       = 11'($urandom_range(0, 2047));
        wif.inject_imbalance = 1'($urandom_range(0, 1));
      end
      reset = 1'($urandom_range(0, 799) == 0);
      step();
      exp_t = ((m_cycles % TDIV) == (TDIV - 1));
      n_checks++; if (wif.water_level_sensor !== 10'(m_level)) begin n_fail++; $display("FAIL rand_level i=%0d got=%0d exp=%0d", i, wif.water_level_sensor, m_level); end
      n_checks++; if (wif.temperature_adc_sensor !== 7'(m_temp)) begin n_fail++; $display("FAIL rand_temp i=%0d got=%0d exp=%0d", i, wif.temperature_adc_sensor, m_temp); end
      n_checks++; if (wif.drum_speed_actual !== 11'(m_speed)) begin n_fail++; $display("FAIL rand_speed i=%0d got=%0d exp=%0d", i, wif.drum_speed_actual, m_speed); end
      n_checks++; if (wif.vibration_sensor !== m_vib) begin n_fail++; $display("FAIL rand_vib i=%0d got=%b exp=%b", i, wif.vibration_sensor, m_vib); end
      n_checks++; if (wif.tick !== exp_t) begin n_fail++; $display("FAIL rand_tick i=%0d got=%b exp=%b", i, wif.tick, exp_t); end
    end
    reset = 1'b0;
  endtask

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_tick();
    test_fill();
    test_drain();
    test_heat();
    test_dry_heat();
    test_ramp();
    test_vibration();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/washer_plant_emulator.md
WASHER_PLANT_EMULATOR -- requirements
Module: washer_plant_emulator

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, clocks per plant tick.
REQ-002 SHALL have parameters FILL_RATE=8, DRAIN_RATE=16, level counts added or removed per tick.
REQ-003 SHALL have parameters AMBIENT_TEMP=20, MAX_TEMP=95, HEAT_TICKS=2, COOL_TICKS=8, HEAT_MIN_LEVEL=100.
REQ-004 SHALL have parameters ACCEL=50 (rpm per tick), VIB_THRESH=800 (rpm), VIB_HOLD=4 (ticks).
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- water_valve  in  1  fill command
- drain_pump  in  1  drain command
- heater  in  1  heater command
- drum_motor  in  11  commanded drum rpm
- inject_no_flow  in  1  fault: valve has no effect
- inject_blocked_drain  in  1  fault: pump has no effect
- inject_imbalance  in  1  fault: unbalanced load
- water_level_sensor  out  10  emulated water level
- temperature_adc_sensor  out  7  emulated temperature, degrees C
- vibration_sensor  out  1  excessive vibration
- drum_speed_actual  out  11  emulated drum rpm
- tick  out  1  one-clock plant-tick strobe

Function
REQ-006 SHALL count clocks 0..TICK_DIV-1 and assert tick for one clock when the count equals TICK_DIV-1, giving the first tick on the TICK_DIV-th clock after reset deasserts.
REQ-007 SHALL update all plant state only on clock edges where tick=1; all outputs are registered.
REQ-008 SHALL treat the effective fill as water_valve AND NOT inject_no_flow, and the effective drain as drain_pump AND NOT inject_blocked_drain.
REQ-009 SHALL update the level per tick as follows:
- fill only: +FILL_RATE
- drain only: -DRAIN_RATE
- both: +FILL_RATE-DRAIN_RATE
- neither: hold
REQ-010 SHALL saturate the level at 1023 and at 0 with no wrap-around; intermediate arithmetic SHALL use at least 12 bits, signed.
REQ-011 SHALL run a heat/cool divider that increments each tick and clears whenever the temperature mode changes.
REQ-012 SHALL increment temperature by 1 every HEAT_TICKS ticks, up to MAX_TEMP, while heater=1 and the level is >= HEAT_MIN_LEVEL.
REQ-013 SHALL otherwise step temperature by 1 toward AMBIENT_TEMP every COOL_TICKS ticks; when heater=1 but the level is < HEAT_MIN_LEVEL, this is dry-heat protection.
REQ-014 SHALL ramp drum_speed_actual toward drum_motor by ACCEL per tick, and SHALL load drum_motor directly when |drum_motor - drum_speed_actual| <= ACCEL, with no overshoot.
REQ-015 SHALL run a vibration FSM with states V_IDLE, V_ARM and V_VIB, evaluated on ticks.
REQ-016 SHALL define the vibration condition hot as inject_imbalance=1 and drum_speed_actual >= VIB_THRESH.
REQ-017 SHALL make these FSM transitions:
- V_IDLE: go to V_ARM when hot; hold counter = 1.
- V_ARM: increment the counter while hot; go to V_VIB when the counter reaches VIB_HOLD; go to V_IDLE when not hot.
- V_VIB: go to V_IDLE when not hot.
REQ-018 SHALL assert vibration_sensor only in V_VIB, registered.
REQ-019 SHALL have drum_motor changes mid-ramp take effect at the next tick, with no ramp restart.

Reset
REQ-020 SHALL set on reset:
- water_level_sensor=0
- temperature_adc_sensor=AMBIENT_TEMP
- drum_speed_actual=0
- vibration_sensor=0
- tick=0
- prescaler and all dividers=0
- vibration FSM=V_IDLE
REQ-021 SHALL have reset asserted mid-operation override any tick in the same cycle.

Structure
REQ-022 SHALL place the plant constants (rates, AMBIENT_TEMP, MAX_TEMP, VIB_THRESH, VIB_HOLD) and the vibration state encoding in a shared washer package used by the controller bench.
REQ-023 SHALL implement the drum ramp as the sub-module drum_speed_ramp (clk, reset, tick, target, actual).
REQ-024 SHALL have an RTL size of 150-300 lines.

Verification
REQ-025 SHALL cover fill: reset, then water_valve=1 for 200 clocks -> 50 ticks -> level=400; then hold 120 more ticks -> saturates at 1023, with no wrap.
REQ-026 SHALL cover drain and faults:
- level=400, drain_pump=1 for 25 ticks -> 0, and stays 0.
- Same stimulus with inject_blocked_drain=1 -> stays 400.
- Both valves on from 0 -> stays 0, since the net is -8.
REQ-027 SHALL cover heat: level=400, heater=1 -> +1 every 2 ticks, 20->95 after 150 ticks, then holds 95; heater=0 -> 94 after 8 ticks.
REQ-028 SHALL cover dry heat: level=50, heater=1 -> temperature holds at AMBIENT 20.
REQ-029 SHALL cover the ramp: drum_motor=1210 from 0 -> 1200 after 24 ticks, 1210 at tick 25; then drum_motor=0 -> decreases 50 per tick to 0.
REQ-030 SHALL cover vibration:
- inject_imbalance=1, drum_motor=1400 -> speed reaches 800 at tick 16 -> vibration_sensor=1 at tick 19, after 4 hot ticks.
- Clearing inject_imbalance -> vibration_sensor=0 at the next tick.
- Reset asserted mid-fill -> all outputs equal the reset values on the next clock.
